mips150_muldiv: RTL and testbench



---
 rtl/mips150_pkg.sv | 22 ++
 rtl/mips150_abs_neg.sv | 13 +
 rtl/mips150_muldiv.sv | 196 +++++++++++++++++++
 tb/tb_mips150_muldiv.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mips150_pkg.sv
// Shared encodings for the MIPS150 multiply/divide unit: op codes, FSM states
// and small op-decode helpers.
package mips150_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mips150_abs_neg.sv
// Combinational conditional two's-complement negate; used both to take operand
// magnitudes and to restore result signs.
module mips150_abs_neg #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mips150_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MIPS150_MULDIV_EARLY_OUT_EN to finish multiplies once the multiplier is exhausted.
module mips150_muldiv
  import mips150_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               op_signed;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_trial;
  logic               div_ge;
  logic               early_out;

  assign op_signed = is_signed_op(op);

  mips150_abs_neg #(.W(WIDTH)) u_mag_a (
    .neg (op_signed & src_a[WIDTH-1]),
    .din (src_a),
    .dout(mag_a)
  );

  mips150_abs_neg #(.W(WIDTH)) u_mag_b (
    .neg (op_signed & src_b[WIDTH-1]),
    .din (src_b),
    .dout(mag_b)
  );

  mips150_abs_neg #(.W(2 * WIDTH)) u_fix_prod (
    .neg (res_neg_q),
    .din (acc_q),
    .dout(prod_fix)
  );

  // A zero divisor yields an all-ones quotient that must not be negated.
  mips150_abs_neg #(.W(WIDTH)) u_fix_quo (
    .neg (res_neg_q & ~div0_q),
    .din (acc_q[WIDTH-1:0]),
    .dout(quo_fix)
  );

  mips150_abs_neg #(.W(WIDTH)) u_fix_rem (
    .neg (rem_neg_q),
    .din (acc_q[2*WIDTH-1:WIDTH]),
    .dout(rem_fix)
  );

  // Restoring step: {remainder, dividend} shifts left; the true difference fits in WIDTH bits.
  assign div_sh    = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_sh >= {1'b0, mcand_q[WIDTH-1:0]};
  assign div_trial = div_sh[WIDTH-1:0] - mcand_q[WIDTH-1:0];

`ifdef MIPS150_MULDIV_EARLY_OUT_EN
  assign early_out = ~is_div_q & (mplier_q[WIDTH-1:1] == '0);
`else
  assign early_out = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          is_div_d  = is_div_op(op);
          res_neg_d = op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          rem_neg_d = op_signed & src_a[WIDTH-1];
          div0_d    = is_div_op(op) & (src_b == '0);
          if (is_div_op(op)) begin
            acc_d    = {{WIDTH{1'b0}}, mag_a};
            mcand_d  = {{WIDTH{1'b0}}, mag_b};
            mplier_d = '0;
          end else begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
          end
        end else begin
          if (hi_we) hi_d = wr_data;
          if (lo_we) lo_d = wr_data;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          acc_d = div_ge ? {div_trial, acc_q[WIDTH-2:0], 1'b1}
                         : {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if ((cnt_q == CNT_LAST) || early_out) state_d = ST_FIX;
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips150_muldiv.sv
// Directed self-checking bench for mips150_muldiv (WIDTH=32), expected values hand-computed.
module tb_mips150_muldiv;
  import mips150_pkg::*;

`ifdef MIPS150_MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int FULL_LAT = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mips150_muldiv #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wr_data(wr_data),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges after the start edge until done; busy must hold until then.
  task automatic wait_done(input string tag, input int exp_lat);
    int cyc = 0;
    bit busy_ok = 1'b1;
    while (!done && cyc < 200) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_hi,
                     input logic [31:0] exp_lo, input int early_lat);
    launch(o, a, b);
    src_a = 32'h0BAD_0BAD; src_b = 32'h0BAD_0BAD;
    wait_done(tag, EARLY ? early_lat : FULL_LAT);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    tick();

    run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 4);
    run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 33);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    run("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 33);
    run("div_neg_zero", OP_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 33);
    run("multu_5x1", OP_MULTU, 32'd5, 32'd1, 32'd0, 32'd5, 2);
    run("mult_x0", OP_MULT, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 2);

    // MTHI/MTLO in idle
    wr_data = 32'hA5A5_A5A5; hi_we = 1'b1;
    tick();
    hi_we = 1'b0;
    check("mthi", 64'(hi), 64'h0000_0000_A5A5_A5A5);
    wr_data = 32'h5A5A_0000; lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    check("mtlo", 64'(lo), 64'h0000_0000_5A5A_0000);

    // start wins over a same-cycle write; strobes and restarts while busy are ignored
    wr_data = 32'h1111_1111; hi_we = 1'b1;
    launch(OP_DIVU, 32'd100, 32'd7);
    hi_we = 1'b0;
    check("start_wins_hi", 64'(hi), 64'h0000_0000_A5A5_A5A5);
    tick(); tick();
    op = OP_MULTU; src_a = 32'd3; src_b = 32'd3;
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("busy_we_hi", 64'(hi), 64'h0000_0000_A5A5_A5A5);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("divu_100_7", FULL_LAT - 5);
    check("divu_100_7_hi", 64'(hi), 64'd2);
    check("divu_100_7_lo", 64'(lo), 64'd14);
    tick();

    // Reset at cycle 10 of a multiply aborts it
    launch(OP_MULT, 32'h1234_5678, 32'h7FFF_FFFF);
    repeat (9) tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    repeat (40) begin
      tick();
      if (done) check("abort_no_done", 64'(done), 64'd0);
    end
    check("abort_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
